step_clk_debounce: RTL and testbench
====================================

Name: step_clk_debounce

Overview:
- Upstream stage of the single-step CPU experiment top.
- Turns the raw, bouncing Step button into a clean, glitch-free step clock level (BTN_Out) that clocks the CPU core.
- Also produces a one-cycle strobe and a step counter for display and debug.
- Runs entirely in the clk_100MHz domain.

Parameters:
- DEBOUNCE_CYCLES, 1000000, cycles BTN must be stable before a level change is accepted (10 ms at 100 MHz); minimum 2.
- CNT_W, 20, width of the debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- STEP_CNT_W, 16, width of step_cnt.
- AUTO_DIV, 50000000, half-period in cycles of the auto-run step clock. Used only with AUTO_RUN_EN.

Ports:
- clk_100MHz  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-low reset.
- BTN  in  1  raw asynchronous push-button, active-high.
- BTN_Out  out  1  debounced step clock level; high while the press is accepted.
- step_pulse  out  1  one-cycle strobe, coincident with every 0->1 of BTN_Out.
- step_cnt  out  STEP_CNT_W  count of accepted steps; wraps modulo 2^STEP_CNT_W.
- run_en  in  1  auto-run select. Present only with AUTO_RUN_EN.

Behaviour:
- Reset: sampled on the clk_100MHz rising edge with rst==0. It clears:
  - state to IDLE;
  - the debounce counter to 0;
  - both synchronizer flops to 0;
  - BTN_Out, step_pulse and step_cnt to 0.
- Reset mid-press or mid-debounce discards all progress. After rst returns to 1, a still-held button must be fully re-debounced (N+3 edges).
- Synchronizer: BTN passes through 2 flops (s1 -> s2). The FSM uses only s2.
- FSM, with N = DEBOUNCE_CYCLES:
  - IDLE (BTN_Out=0): if s2==1, go to ARM_H with cnt=0.
  - ARM_H (BTN_Out=0):
    - s2==0: go to IDLE, cnt=0.
    - else if cnt==N-1: go to HIGH; register BTN_Out=1 and step_pulse=1; step_cnt+=1.
    - else cnt+=1.
  - HIGH (BTN_Out=1): if s2==0, go to ARM_L with cnt=0.
  - ARM_L (BTN_Out=1):
    - s2==1: go to HIGH, cnt=0 (no pulse, no count).
    - else if cnt==N-1: go to IDLE; register BTN_Out=0.
    - else cnt+=1.
- Latency: count the first rising edge that samples BTN high as edge 1. BTN_Out and step_pulse are high after edge N+3. The release is symmetric: BTN_Out falls after edge N+3.
- step_pulse is high for exactly one cycle per accepted press. It is never asserted on release.
- Any bounce shorter than N consecutive stable samples in ARM_H or ARM_L aborts that transition. Net effect: no BTN_Out change, no pulse, no count.
- step_cnt wraps from 2^STEP_CNT_W-1 to 0 with no flag.
- All outputs are registered; there are no combinational paths from BTN to any output.

Optional Feature:
- Macro: AUTO_RUN_EN.
- Defined:
  - The run_en port exists.
  - When run_en==1:
    - The button FSM is held in IDLE with cnt=0.
    - A divider toggles BTN_Out every AUTO_DIV cycles, starting low.
    - Each 0->1 toggle asserts step_pulse for one cycle and increments step_cnt.
  - When run_en goes 1->0:
    - BTN_Out is forced to 0 on the next edge.
    - The divider clears and button operation resumes from IDLE.
  - run_en is treated as quasi-static. It is not synchronized and is not debounced.
- Undefined: no run_en port, no divider logic; button-only behaviour as above.

Test Plan (DEBOUNCE_CYCLES=4, AUTO_DIV=3, STEP_CNT_W=4):
- Reset: rst=0 for 2 cycles with BTN=1 -> BTN_Out=0, step_pulse=0, step_cnt=0. Release rst with BTN held -> BTN_Out rises after edge 7 counted from the first post-reset edge.
- Clean press: BTN 0->1 held 20 cycles -> BTN_Out=1 and step_pulse=1 after edge 7; step_pulse=0 on edge 8; step_cnt=1.
- Press bounce: BTN pattern 1,1,0,1,1,1,0 repeating for 30 cycles -> BTN_Out stays 0, step_cnt stays 0. Then hold BTN=1 -> one pulse, step_cnt=1.
- Release bounce: from HIGH, drive BTN 0,0,1,0,0,0,1 -> BTN_Out stays 1, no pulse. Then hold BTN=0 for 10 cycles -> BTN_Out=0; step_cnt unchanged.
- Wrap: 17 clean presses -> step_cnt sequence 1..15, 0, 1; exactly 17 step_pulse strobes.
- AUTO_RUN_EN defined, run_en=1 for 20 cycles:
  - BTN_Out toggles every 3 cycles;
  - step_pulse fires on rises only (≈3 rises in 20 cycles);
  - step_cnt counts the rises.
  - Then run_en=0 -> BTN_Out=0 on the next edge.

Source files
------------

// File: rtl/step_clk_debounce.sv
// step_clk_debounce
// Turns the raw, bouncing Step push-button into a clean step clock level for
// the single-step CPU core. It also provides a one-cycle strobe on every
// accepted press and a wrapping count of accepted steps.
// Everything runs in the clk_100MHz domain.
//
// Ports:
//   clk_100MHz  in   system clock, the only clock
//   rst         in   synchronous active-low reset
//   BTN         in   raw asynchronous push-button, active-high
//   run_en      in   auto-run select (only with AUTO_RUN_EN)
//   BTN_Out     out  debounced step clock level
//   step_pulse  out  one-cycle strobe on every 0->1 of BTN_Out
//   step_cnt    out  accepted-step count, wraps modulo 2^STEP_CNT_W
//
// Optional feature macro: AUTO_RUN_EN.
// When it is defined, the run_en port and a free-running step clock divider
// with half-period AUTO_DIV are added.
module step_clk_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 20,
    parameter int unsigned STEP_CNT_W      = 16
`ifdef AUTO_RUN_EN
    ,
    parameter int unsigned AUTO_DIV        = 50000000
`endif
) (
    input  logic                  clk_100MHz,
    input  logic                  rst,
    input  logic                  BTN,
`ifdef AUTO_RUN_EN
    input  logic                  run_en,
`endif
    output logic                  BTN_Out,
    output logic                  step_pulse,
    output logic [STEP_CNT_W-1:0] step_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM_H = 2'd1,
        HIGH  = 2'd2,
        ARM_L = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef AUTO_RUN_EN
    localparam int unsigned DIV_W = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(AUTO_DIV - 1);
`endif

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  s1_q, s2_q;
    logic                  out_q, out_d;
    logic                  pulse_q, pulse_d;
    logic [STEP_CNT_W-1:0] step_cnt_q, step_cnt_d;
`ifdef AUTO_RUN_EN
    logic [DIV_W-1:0]      div_q, div_d;
    logic                  run_q;
`endif

    // State, synchronizer and output registers
    always_ff @(posedge clk_100MHz) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            out_q      <= 1'b0;
            pulse_q    <= 1'b0;
            step_cnt_q <= '0;
`ifdef AUTO_RUN_EN
            div_q      <= '0;
            run_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            s1_q       <= BTN;
            s2_q       <= s1_q;
            out_q      <= out_d;
            pulse_q    <= pulse_d;
            step_cnt_q <= step_cnt_d;
`ifdef AUTO_RUN_EN
            div_q      <= div_d;
            run_q      <= run_en;
`endif
        end
    end

    // Next-state logic: debounce FSM, plus the auto-run override when enabled
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pulse_d    = 1'b0;
        step_cnt_d = step_cnt_q;
        out_d      = 1'b0;
`ifdef AUTO_RUN_EN
        div_d      = '0;
`endif

        unique case (state_q)
            IDLE: begin
                if (s2_q) begin
                    state_d = ARM_H;
                    cnt_d   = '0;
                end
            end
            ARM_H: begin
                if (!s2_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = HIGH;
                    cnt_d      = '0;
                    pulse_d    = 1'b1;
                    step_cnt_d = step_cnt_q + STEP_CNT_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HIGH: begin
                if (!s2_q) begin
                    state_d = ARM_L;
                    cnt_d   = '0;
                end
            end
            ARM_L: begin
                if (s2_q) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // The level is high exactly while a press is accepted (HIGH or ARM_L)
        out_d = (state_d == HIGH) || (state_d == ARM_L);

`ifdef AUTO_RUN_EN
        if (run_en) begin
            // The button FSM is parked while the divider drives the step clock
            state_d    = IDLE;
            cnt_d      = '0;
            pulse_d    = 1'b0;
            step_cnt_d = step_cnt_q;
            if (!run_q) begin
                // On the first auto-run cycle, start from a known low level
                out_d = 1'b0;
                div_d = '0;
            end else if (div_q == DIV_LAST) begin
                out_d = ~out_q;
                div_d = '0;
                if (!out_q) begin
                    pulse_d    = 1'b1;
                    step_cnt_d = step_cnt_q + STEP_CNT_W'(1);
                end
            end else begin
                out_d = out_q;
                div_d = div_q + DIV_W'(1);
            end
        end else if (run_q) begin
            // Leaving auto-run: drop the level and resume the button from IDLE
            state_d    = IDLE;
            cnt_d      = '0;
            out_d      = 1'b0;
            pulse_d    = 1'b0;
            step_cnt_d = step_cnt_q;
        end
`endif
    end

    assign BTN_Out    = out_q;
    assign step_pulse = pulse_q;
    assign step_cnt   = step_cnt_q;

endmodule

// File: tb/tb_step_clk_debounce.sv
// Testbench for step_clk_debounce (default build, button-only).
// The table records are applied one clock each and checked 1 ns after the
// edge. A hand-written loop covers the step counter wrap.
module tb_step_clk_debounce;

    localparam int unsigned N_DB = 4;

    logic       clk;
    logic       rst;
    logic       btn;
    logic       btn_out;
    logic       step_pulse;
    logic [3:0] step_cnt;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    step_clk_debounce #(
        .DEBOUNCE_CYCLES(N_DB),
        .CNT_W          (3),
        .STEP_CNT_W     (4)
    ) dut (
        .clk_100MHz(clk),
        .rst       (rst),
        .BTN       (btn),
        .BTN_Out   (btn_out),
        .step_pulse(step_pulse),
        .step_cnt  (step_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       btn;
        logic       e_out;
        logic       e_pulse;
        logic [3:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic r, input logic b, input logic o,
                                input logic p, input logic [3:0] c);
        vec_t v;
        v.rst = r; v.btn = b; v.e_out = o; v.e_pulse = p; v.e_cnt = c;
        tbl.push_back(v);
    endfunction

    function automatic void add_n(input int n, input logic r, input logic b,
                                  input logic o, input logic p, input logic [3:0] c);
        for (int k = 0; k < n; k++) add(r, b, o, p, c);
    endfunction

    task automatic check1(input string name, input int idx, input logic [3:0] got,
                          input logic [3:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s[%0d]: got %0d want %0d", name, idx, got, want);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic pat_press[7];
    logic pat_rel[7];
    int   pulses;
    int   waited;
    logic [3:0] exp_cnt;

    initial begin
        rst = 1'b0;
        btn = 1'b0;
        pat_press = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        pat_rel   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset with BTN held, then release reset: rise after 7th edge
        add_n(2, 0, 1, 0, 0, 0);
        add_n(6, 1, 1, 0, 0, 0);
        add  (   1, 1, 1, 1, 1);
        add_n(3, 1, 1, 1, 0, 1);
        add_n(6, 1, 0, 1, 0, 1);
        add_n(4, 1, 0, 0, 0, 1);
        // Reset, then a clean press and release
        add_n(2, 0, 0, 0, 0, 0);
        add_n(6, 1, 1, 0, 0, 0);
        add  (   1, 1, 1, 1, 1);
        add_n(13, 1, 1, 1, 0, 1);
        add_n(6, 1, 0, 1, 0, 1);
        add_n(4, 1, 0, 0, 0, 1);
        // Press bounce: at most 3 consecutive highs, so the press is never accepted
        for (int i = 0; i < 30; i++) add(1, pat_press[i % 7], 0, 0, 1);
        // The pattern ends in 0,1,1, so the last two samples begin the accepted run
        add_n(4, 1, 1, 0, 0, 1);
        add  (   1, 1, 1, 1, 2);
        add_n(5, 1, 1, 1, 0, 2);
        // Release bounce from HIGH, then a steady release
        for (int j = 0; j < 7; j++) add(1, pat_rel[j], 1, 0, 2);
        add_n(6, 1, 0, 1, 0, 2);
        add_n(4, 1, 0, 0, 0, 2);
        // Reset in the middle of the debounce: the full latency applies again
        add_n(4, 1, 1, 0, 0, 2);
        add  (   0, 1, 0, 0, 0);
        add_n(6, 1, 1, 0, 0, 0);
        add  (   1, 1, 1, 1, 1);
        add_n(2, 1, 1, 1, 0, 1);
        // Reset from HIGH clears the level and the count
        add  (   0, 1, 0, 0, 0);
        add_n(3, 1, 0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst;
            btn = tbl[i].btn;
            tick();
            check1("BTN_Out",    i, {3'b0, btn_out},    {3'b0, tbl[i].e_out});
            check1("step_pulse", i, {3'b0, step_pulse}, {3'b0, tbl[i].e_pulse});
            check1("step_cnt",   i, step_cnt,           tbl[i].e_cnt);
        end

        // Wrap: 17 clean presses, count sequence 1..15, 0, 1
        pulses = 0;
        for (int p = 1; p <= 17; p++) begin
            btn    = 1'b1;
            waited = 0;
            do begin
                tick();
                waited++;
            end while (!step_pulse && waited < 12);
            if (step_pulse) pulses++;
            exp_cnt = 4'(p);
            check1("wrap_latency", p, 4'(waited), 4'(N_DB + 3));
            check1("wrap_cnt",     p, step_cnt,   exp_cnt);
            tick();
            check1("wrap_pulse_width", p, {3'b0, step_pulse}, 4'd0);
            btn = 1'b0;
            for (int k = 0; k < 10; k++) begin
                tick();
                if (step_pulse) pulses++;
            end
            check1("wrap_release", p, {3'b0, btn_out}, 4'd0);
        end
        check1("wrap_pulse_total", 0, 4'(pulses), 4'(17));
        n_checks++;
        if (pulses == 17) n_pass++;
        else $display("FAIL wrap_pulse_count: got %0d want 17", pulses);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
